// File: rtl/flip_scan_controller.sv
// Reversi move sequencer: scans 8 directions from the target, strobes reversals, then places the piece.
// Optional FLIP_SCAN_DRY_RUN_EN adds check_only, which runs the scan with every write strobe masked.
module flip_scan_controller #(
    parameter int BOARD_DIM = 8,
    parameter int ADDR_W    = 6,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              move_valid,
    input  logic [2:0]        move_row,
    input  logic [2:0]        move_col,
    input  logic              move_black,
`ifdef FLIP_SCAN_DRY_RUN_EN
    input  logic              check_only,
`endif
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_play,
    output logic              wr_reverse,
    output logic              wr_set_black,
    output logic              busy,
    output logic              done,
    output logic              legal,
    output logic [CNT_W-1:0]  flip_count
);

    localparam logic [2:0] SQ_EMPTY = 3'b000;
    localparam logic [2:0] SQ_BLACK = 3'b111;
    localparam logic [2:0] SQ_WHITE = 3'b110;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK_REQ,
        S_CHECK_EVAL,
        S_DIR,
        S_STEP_REQ,
        S_STEP_EVAL,
        S_FLIP,
        S_PLACE_EN,
        S_PLACE,
        S_DONE
    } state_t;

    state_t                   state_q, state_n;
    logic signed [4:0]        org_row_q, org_row_n;
    logic signed [4:0]        org_col_q, org_col_n;
    logic signed [4:0]        pos_row_q, pos_row_n;
    logic signed [4:0]        pos_col_q, pos_col_n;
    logic                     black_q, black_n;
    logic                     was_empty_q, was_empty_n;
    logic [2:0]               dir_q, dir_n;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_n;
    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_n;
    logic [CNT_W-1:0]         cnt_q, cnt_n;
    logic                     legal_q, legal_n;
    logic                     dir_end;
    logic                     accept;
    logic                     dry;

    logic signed [4:0]        dr, dc;
    logic signed [4:0]        first_row, first_col;
    logic signed [4:0]        step_row, step_col;
    logic signed [4:0]        back_row, back_col;
    logic                     back_is_org;
    logic [2:0]               own, opp;

    // Unit vector for direction d, clockwise from north.
    function automatic logic signed [4:0] dir_dr(input logic [2:0] d);
        case (d)
            3'd0, 3'd1, 3'd7: dir_dr = -5'sd1;
            3'd2, 3'd6:       dir_dr = 5'sd0;
            default:          dir_dr = 5'sd1;
        endcase
    endfunction

    function automatic logic signed [4:0] dir_dc(input logic [2:0] d);
        case (d)
            3'd0, 3'd4:       dir_dc = 5'sd0;
            3'd1, 3'd2, 3'd3: dir_dc = 5'sd1;
            default:          dir_dc = -5'sd1;
        endcase
    endfunction

    function automatic logic in_bounds(input logic signed [4:0] r, input logic signed [4:0] c);
        in_bounds = (int'(r) >= 0) && (int'(r) < BOARD_DIM) &&
                    (int'(c) >= 0) && (int'(c) < BOARD_DIM);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic signed [4:0] r, input logic signed [4:0] c);
        addr_of = ADDR_W'(int'(r) * BOARD_DIM + int'(c));
    endfunction

    assign dr          = dir_dr(dir_q);
    assign dc          = dir_dc(dir_q);
    assign first_row   = org_row_q + dr;
    assign first_col   = org_col_q + dc;
    assign step_row    = pos_row_q + dr;
    assign step_col    = pos_col_q + dc;
    assign back_row    = pos_row_q - dr;
    assign back_col    = pos_col_q - dc;
    // Stepping back onto the origin means the run has no squares left to reverse.
    assign back_is_org = (back_row == org_row_q) && (back_col == org_col_q);
    assign own         = black_q ? SQ_BLACK : SQ_WHITE;
    assign opp         = black_q ? SQ_WHITE : SQ_BLACK;
    assign accept      = ((state_q == S_IDLE) || (state_q == S_DONE)) && move_valid;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q     <= S_IDLE;
            org_row_q   <= '0;
            org_col_q   <= '0;
            pos_row_q   <= '0;
            pos_col_q   <= '0;
            black_q     <= 1'b0;
            was_empty_q <= 1'b0;
            dir_q       <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            cnt_q       <= '0;
            legal_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            org_row_q   <= org_row_n;
            org_col_q   <= org_col_n;
            pos_row_q   <= pos_row_n;
            pos_col_q   <= pos_col_n;
            black_q     <= black_n;
            was_empty_q <= was_empty_n;
            dir_q       <= dir_n;
            rd_addr_q   <= rd_addr_n;
            wr_addr_q   <= wr_addr_n;
            cnt_q       <= cnt_n;
            legal_q     <= legal_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        org_row_n   = org_row_q;
        org_col_n   = org_col_q;
        pos_row_n   = pos_row_q;
        pos_col_n   = pos_col_q;
        black_n     = black_q;
        was_empty_n = was_empty_q;
        dir_n       = dir_q;
        rd_addr_n   = rd_addr_q;
        wr_addr_n   = wr_addr_q;
        cnt_n       = cnt_q;
        legal_n     = legal_q;
        dir_end     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                if (accept) begin
                    org_row_n = {2'b00, move_row};
                    org_col_n = {2'b00, move_col};
                    black_n   = move_black;
                    cnt_n     = '0;
                    legal_n   = 1'b0;
                    if ((int'(move_row) >= BOARD_DIM) || (int'(move_col) >= BOARD_DIM)) begin
                        state_n = S_DONE;
                    end else begin
                        rd_addr_n = addr_of({2'b00, move_row}, {2'b00, move_col});
                        state_n   = S_CHECK_REQ;
                    end
                end
            end
            S_CHECK_REQ: state_n = S_CHECK_EVAL;
            S_CHECK_EVAL: begin
                if ((rd_data == SQ_BLACK) || (rd_data == SQ_WHITE)) begin
                    state_n = S_DONE;
                end else begin
                    was_empty_n = (rd_data == SQ_EMPTY);
                    dir_n       = '0;
                    state_n     = S_DIR;
                end
            end
            S_DIR: begin
                if (in_bounds(first_row, first_col)) begin
                    pos_row_n = first_row;
                    pos_col_n = first_col;
                    rd_addr_n = addr_of(first_row, first_col);
                    state_n   = S_STEP_REQ;
                end else begin
                    dir_end = 1'b1;
                end
            end
            S_STEP_REQ: state_n = S_STEP_EVAL;
            S_STEP_EVAL: begin
                if (rd_data == opp) begin
                    if (in_bounds(step_row, step_col)) begin
                        pos_row_n = step_row;
                        pos_col_n = step_col;
                        rd_addr_n = addr_of(step_row, step_col);
                        state_n   = S_STEP_REQ;
                    end else begin
                        dir_end = 1'b1;
                    end
                end else if ((rd_data == own) && !back_is_org) begin
                    pos_row_n = back_row;
                    pos_col_n = back_col;
                    wr_addr_n = addr_of(back_row, back_col);
                    state_n   = S_FLIP;
                end else begin
                    dir_end = 1'b1;
                end
            end
            S_FLIP: begin
                cnt_n = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                if (back_is_org) begin
                    dir_end = 1'b1;
                end else begin
                    pos_row_n = back_row;
                    pos_col_n = back_col;
                    wr_addr_n = addr_of(back_row, back_col);
                end
            end
            S_PLACE_EN: state_n = S_PLACE;
            S_PLACE: begin
                legal_n = 1'b1;
                state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase

        // After the last direction: nothing captured ends illegal, otherwise place.
        if (dir_end) begin
            if (dir_q == 3'd7) begin
                if (cnt_n == '0) begin
                    state_n = S_DONE;
                end else begin
                    state_n   = was_empty_q ? S_PLACE_EN : S_PLACE;
                    wr_addr_n = addr_of(org_row_q, org_col_q);
                end
            end else begin
                dir_n   = dir_q + 3'd1;
                state_n = S_DIR;
            end
        end
    end

`ifdef FLIP_SCAN_DRY_RUN_EN
    logic dry_q;

    always_ff @(posedge clk) begin
        if (resetn)
            dry_q <= 1'b0;
        else if (accept)
            dry_q <= check_only;
    end

    assign dry = dry_q;
`else
    assign dry = 1'b0;
`endif

    assign rd_addr      = rd_addr_q;
    assign wr_addr      = wr_addr_q;
    assign wr_reverse   = (state_q == S_FLIP) && !dry;
    assign wr_play      = ((state_q == S_PLACE_EN) || (state_q == S_PLACE)) && !dry;
    assign wr_set_black = wr_play && black_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign legal        = legal_q;
    assign flip_count   = cnt_q;

endmodule

// File: tb/tb_flip_scan_controller.sv
// Randomized bench for flip_scan_controller with a ray-walking reversi model and a board of node behaviours.
module tb_flip_scan_controller;

    localparam logic [2:0] EMP = 3'b000;
    localparam logic [2:0] ENA = 3'b100;
    localparam logic [2:0] BLK = 3'b111;
    localparam logic [2:0] WHT = 3'b110;

    logic       clk = 1'b0;
    logic       resetn;
    logic       move_valid;
    logic [2:0] move_row;
    logic [2:0] move_col;
    logic       move_black;
    logic [5:0] rd_addr;
    logic [2:0] rd_data;
    logic [5:0] wr_addr;
    logic       wr_play;
    logic       wr_reverse;
    logic       wr_set_black;
    logic       busy;
    logic       done;
    logic       legal;
    logic [4:0] flip_count;
`ifdef FLIP_SCAN_DRY_RUN_EN
    logic       check_only;
`endif

    logic [2:0] board [64];
    logic [2:0] setup [64];
    logic       load;

    int DR [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    int DC [8] = '{ 0,  1, 1, 1, 0, -1, -1, -1};

    int exp_q [$];
    int obs_q [$];
    int exp_cnt, exp_legal;
    bit active;
    int n_cmp, n_fail, n_done, start_done;
    int cyc, acc_cyc, done_cyc;
    int last_legal, last_fc;
    int ev, ex;

    flip_scan_controller dut (
        .clk          (clk),
        .resetn       (resetn),
        .move_valid   (move_valid),
        .move_row     (move_row),
        .move_col     (move_col),
        .move_black   (move_black),
`ifdef FLIP_SCAN_DRY_RUN_EN
        .check_only   (check_only),
`endif
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wr_addr      (wr_addr),
        .wr_play      (wr_play),
        .wr_reverse   (wr_reverse),
        .wr_set_black (wr_set_black),
        .busy         (busy),
        .done         (done),
        .legal        (legal),
        .flip_count   (flip_count)
    );

    always #5 clk = ~clk;

    // Board of node state machines: registered read port, strobes update squares.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) board[i] <= setup[i];
        end else begin
            if (wr_reverse) board[wr_addr] <= (board[wr_addr] == BLK) ? WHT : BLK;
            if (wr_play) board[wr_addr] <= (board[wr_addr] == EMP) ? ENA : (wr_set_black ? BLK : WHT);
        end
        rd_data <= board[rd_addr];
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic bit inb(input int r, input int c);
        return (r >= 0) && (r < 8) && (c >= 0) && (c < 8);
    endfunction

    // Reference: walk each ray over the board, list reversals nearest-last, then the placement.
    task automatic build_expect(input int r, input int c, input bit blk, input bit co);
        logic [2:0] t, own, opp;
        int k, n, pe;
        exp_q.delete();
        exp_cnt = 0;
        exp_legal = 0;
        if (!inb(r, c)) return;
        t = board[r*8 + c];
        if (t == BLK || t == WHT) return;
        own = blk ? BLK : WHT;
        opp = blk ? WHT : BLK;
        n = 0;
        for (int d = 0; d < 8; d++) begin
            k = 1;
            while (inb(r + k*DR[d], c + k*DC[d]) && board[(r + k*DR[d])*8 + c + k*DC[d]] == opp) k++;
            if (k > 1 && inb(r + k*DR[d], c + k*DC[d]) && board[(r + k*DR[d])*8 + c + k*DC[d]] == own) begin
                for (int j = k - 1; j >= 1; j--) begin
                    n++;
                    if (!co) exp_q.push_back((r + j*DR[d])*8 + c + j*DC[d]);
                end
            end
        end
        exp_cnt = (n > 31) ? 31 : n;
        exp_legal = (n > 0) ? 1 : 0;
        if (n > 0 && !co) begin
            pe = 1000 + (blk ? 100 : 0) + r*8 + c;
            if (t == EMP) exp_q.push_back(pe);
            exp_q.push_back(pe);
        end
    endtask

    task automatic clear_setup();
        for (int i = 0; i < 64; i++) setup[i] = EMP;
    endtask

    task automatic put(input int r, input int c, input logic [2:0] v);
        setup[r*8 + c] = v;
    endtask

    task automatic opening();
        clear_setup();
        put(3, 3, WHT); put(4, 4, WHT); put(3, 4, BLK); put(4, 3, BLK);
    endtask

    task automatic issue_move(input int r, input int c, input bit b);
        load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        move_row = 3'(r);
        move_col = 3'(c);
        move_black = b;
        move_valid = 1'b1;
        start_done = n_done;
        @(posedge clk); #1 move_valid = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (n_done == start_done && i < 2000) begin
            @(negedge clk);
            i++;
        end
        if (n_done == start_done) chk("timeout", n_done - start_done, 1);
    endtask

    task automatic chk_obs(input string nm, input int e[$]);
        chk({nm, "_len"}, obs_q.size(), e.size());
        foreach (e[i]) chk(nm, (i < obs_q.size()) ? obs_q[i] : -1, e[i]);
    endtask

    initial begin
        int e[$];
        int v, r, c, found;
        resetn = 1'b1;
        load = 1'b0;
        move_valid = 1'b0;
        move_row = '0;
        move_col = '0;
        move_black = 1'b0;
`ifdef FLIP_SCAN_DRY_RUN_EN
        check_only = 1'b0;
`endif
        clear_setup();

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (resetn) begin
                    active = 0;
                    exp_q.delete();
                end else begin
                    if (wr_play || wr_reverse) begin
                        chk("strobe_excl", int'(wr_play && wr_reverse), 0);
                        ev = wr_play ? 1000 + (wr_set_black ? 100 : 0) + int'(wr_addr) : int'(wr_addr);
                        ex = (active && exp_q.size() > 0) ? exp_q.pop_front() : -1;
                        chk("strobe", ev, ex);
                        obs_q.push_back(ev);
                    end
                    if (done) begin
                        chk("done_active", int'(active), 1);
                        chk("done_busy", int'(busy), 0);
                        chk("done_leftover", exp_q.size(), 0);
                        chk("legal", int'(legal), exp_legal);
                        chk("flip_count", int'(flip_count), exp_cnt);
                        last_legal = int'(legal);
                        last_fc = int'(flip_count);
                        done_cyc = cyc;
                        active = 0;
                        n_done++;
                    end else if (active) begin
                        chk("busy", int'(busy), 1);
                    end
                    if (move_valid && !busy) begin
`ifdef FLIP_SCAN_DRY_RUN_EN
                        build_expect(int'(move_row), int'(move_col), move_black, check_only);
`else
                        build_expect(int'(move_row), int'(move_col), move_black, 1'b0);
`endif
                        active = 1;
                        acc_cyc = cyc;
                        obs_q.delete();
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_play", int'(wr_play), 0);
        chk("rst_reverse", int'(wr_reverse), 0);
        chk("rst_legal", int'(legal), 0);
        chk("rst_flip_count", int'(flip_count), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        resetn = 1'b0;
        repeat (2) @(negedge clk);

        // Opening move: black (2,3) flips (3,3)
        opening();
        issue_move(2, 3, 1'b1);
        wait_done();
        e = '{27, 1119, 1119};
        chk_obs("s1_events", e);
        chk("s1_legal", last_legal, 1);
        chk("s1_fc", last_fc, 1);

        // Occupied target
        opening();
        issue_move(3, 3, 1'b1);
        wait_done();
        chk("s2_nstrobe", obs_q.size(), 0);
        chk("s2_legal", last_legal, 0);
        chk("s2_latency_ok", int'(done_cyc - acc_cyc <= 4), 1);

        // Long edge capture
        clear_setup();
        put(0, 0, ENA);
        for (int i = 1; i <= 6; i++) put(0, i, WHT);
        put(0, 7, BLK);
        issue_move(0, 0, 1'b1);
        wait_done();
        e = '{6, 5, 4, 3, 2, 1, 1100};
        chk_obs("s3_events", e);
        chk("s3_fc", last_fc, 6);

        // Unterminated run
        clear_setup();
        put(0, 0, ENA);
        for (int i = 1; i <= 7; i++) put(0, i, WHT);
        issue_move(0, 0, 1'b1);
        wait_done();
        chk("s4_nstrobe", obs_q.size(), 0);
        chk("s4_legal", last_legal, 0);

        // Multi-direction with an ignored move_valid pulse mid-scan
        clear_setup();
        put(2, 3, WHT); put(2, 4, WHT); put(2, 5, BLK);
        put(3, 2, WHT); put(4, 2, WHT); put(5, 2, BLK);
        issue_move(2, 2, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        move_row = 3'd7; move_col = 3'd7; move_black = 1'b0; move_valid = 1'b1;
        @(posedge clk); #1 move_valid = 1'b0;
        wait_done();
        e = '{20, 19, 34, 26, 1118, 1118};
        chk_obs("s5_events", e);
        chk("s5_fc", last_fc, 4);
        repeat (3) @(negedge clk);
        chk("s5_no_second", int'(busy), 0);

        // Reset in the middle of FLIP
        clear_setup();
        put(0, 0, ENA);
        for (int i = 1; i <= 6; i++) put(0, i, WHT);
        put(0, 7, BLK);
        issue_move(0, 0, 1'b1);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (wr_reverse) found = 1;
        end
        chk("s6_saw_flip", found, 1);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("s6_busy", int'(busy), 0);
        chk("s6_reverse", int'(wr_reverse), 0);
        chk("s6_play", int'(wr_play), 0);
        chk("s6_done", int'(done), 0);
        chk("s6_legal", int'(legal), 0);
        chk("s6_fc", int'(flip_count), 0);
        #1 resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s6_no_done", int'(done), 0);
        end

`ifdef FLIP_SCAN_DRY_RUN_EN
        opening();
        check_only = 1'b1;
        issue_move(2, 3, 1'b1);
        wait_done();
        check_only = 1'b0;
        chk("dry_nstrobe", obs_q.size(), 0);
        chk("dry_legal", last_legal, 1);
        chk("dry_fc", last_fc, 1);
`endif

        // Random boards against the model
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < 64; i++) begin
                v = $urandom_range(0, 9);
                setup[i] = (v < 4) ? WHT : (v < 8) ? BLK : (v == 8) ? EMP : ENA;
            end
            r = $urandom_range(0, 7);
            c = $urandom_range(0, 7);
            if ($urandom_range(0, 4) != 0) put(r, c, ($urandom_range(0, 1) != 0) ? EMP : ENA);
            issue_move(r, c, 1'($urandom_range(0, 1)));
            wait_done();
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
